// File: rtl/fft8_frame_loader.sv
// Purpose: serial-to-parallel loader; gathers N samples into a fill bank and hands them to a hold bank.
// Latency: frame_valid rises one edge after the edge that accepts the Nth sample, if the hold bank is free.
// Backpressure: din_ready falls only when the fill bank is full and the held frame is not being taken.
module fft8_frame_loader #(
  parameter int W = 12,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           din_first,
  output logic           din_ready,
  output logic [N*W-1:0] frame,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [7:0]     frame_seq,
  output logic [7:0]     drop_cnt
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(N);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  logic [N*W-1:0] fill_q, fill_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N*W-1:0] frame_q, frame_d;
  logic           frame_valid_q, frame_valid_d;
  logic [7:0]     frame_seq_q, frame_seq_d;
  logic [7:0]     next_seq_q, next_seq_d;
  logic [7:0]     drop_q, drop_d;

  logic           full;
  logic           hold_free;
  logic           move;
  logic           accept;
  logic [CW-1:0]  base;

  // Handshake decode: a full fill bank empties into the hold bank whenever the hold bank is free.
  always_comb begin
    full      = (count_q == COUNT_FULL);
    hold_free = !frame_valid_q || frame_ready;
    move      = full && hold_free;
    din_ready = !full || hold_free;
    accept    = din_valid && din_ready;
    // Write position after a same-cycle move restarts at slot 0.
    base      = move ? '0 : count_q;
  end

  // Next-state: hold bank update on move/transfer, fill bank write and partial-frame abort on accept.
  always_comb begin
    fill_d        = fill_q;
    count_d       = base;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    frame_seq_d   = frame_seq_q;
    next_seq_d    = next_seq_q;
    drop_d        = drop_q;

    if (move) begin
      frame_d       = fill_q;
      frame_valid_d = 1'b1;
      frame_seq_d   = next_seq_q;
      next_seq_d    = next_seq_q + 8'd1;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    if (accept) begin
      if (din_first && (base != '0)) begin
        // A new frame start abandons the partial frame; only the count matters, stale slots get overwritten.
        fill_d[W-1:0] = din;
        count_d       = COUNT_ONE;
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (CW'(k) == base) begin
            fill_d[k*W +: W] = din;
          end
        end
        count_d = base + COUNT_ONE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q        <= '0;
      count_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_seq_q   <= 8'd0;
      next_seq_q    <= 8'd0;
      drop_q        <= 8'd0;
    end else begin
      fill_q        <= fill_d;
      count_q       <= count_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_seq_q   <= frame_seq_d;
      next_seq_q    <= next_seq_d;
      drop_q        <= drop_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_seq   = frame_seq_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Self-checking bench for fft8_frame_loader against a queue-based transaction model.
module tb_fft8_frame_loader;
  localparam int W = 12;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           din_first = 1'b0;
  logic           din_ready;
  logic [N*W-1:0] frame;
  logic           frame_valid;
  logic           frame_ready = 1'b0;
  logic [7:0]     frame_seq;
  logic [7:0]     drop_cnt;

  fft8_frame_loader #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_first(din_first),
    .din_ready(din_ready), .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_seq(frame_seq), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: samples collected so far, the presented frame, counters.
  logic [W-1:0]   m_fill[$];
  logic           m_hv;
  logic [N*W-1:0] m_hold;
  logic [7:0]     m_seq;
  int             m_next_seq;
  int             m_drop;

  logic [N*W-1:0] got_f[$];
  logic [7:0]     got_s[$];
  logic [N*W-1:0] exp_f[$];
  logic [7:0]     exp_s[$];
  int             xfer_cyc[$];
  int             cyc;
  int             rdy_lows;
  int             state_bad;
  logic           last_rdy;
  logic [W-1:0]   smp[0:31];

  function automatic logic [N*W-1:0] pack_smp(input int start);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = smp[start + k];
    return v;
  endfunction

  task automatic do_reset(input int cycles);
    din_valid = 1'b0;
    din_first = 1'b0;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_fill.delete();
    m_hv = 1'b0; m_hold = '0; m_seq = 8'd0; m_next_seq = 0; m_drop = 0;
    got_f.delete(); got_s.delete(); exp_f.delete(); exp_s.delete(); xfer_cyc.delete();
    cyc = 0; rdy_lows = 0; state_bad = 0;
  endtask

  // One clock: drive inputs, observe before the edge, advance the model by what the edge does.
  task automatic step(input logic v, input logic f, input logic [W-1:0] d, input logic fr);
    logic hold_free, full, erdy, xfer;
    logic [N*W-1:0] pv;
    din_valid = v; din_first = f; din = d; frame_ready = fr;
    @(negedge clk);
    hold_free = !m_hv || fr;
    full = (m_fill.size() == N);
    erdy = !full || hold_free;
    last_rdy = din_ready;
    if (din_ready !== 1'b1) rdy_lows++;
    if (din_ready !== erdy || frame_valid !== m_hv || frame_seq !== m_seq ||
        drop_cnt !== 8'(m_drop) || (m_hv && frame !== m_hold)) state_bad++;
    xfer = m_hv && fr;
    if (xfer) begin
      got_f.push_back(frame); got_s.push_back(frame_seq);
      exp_f.push_back(m_hold); exp_s.push_back(m_seq);
      xfer_cyc.push_back(cyc);
    end
    if (full && hold_free) begin
      pv = '0;
      for (int k = 0; k < N; k++) pv[k*W +: W] = m_fill[k];
      m_hold = pv; m_hv = 1'b1; m_seq = 8'(m_next_seq);
      m_next_seq = (m_next_seq + 1) % 256;
      m_fill.delete();
    end else if (xfer) begin
      m_hv = 1'b0;
    end
    if (v && erdy) begin
      if (f && m_fill.size() > 0 && m_fill.size() < N) begin
        if (m_drop < 255) m_drop++;
        m_fill.delete();
      end
      m_fill.push_back(d);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    do_reset(2);
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got=%b want=0", frame_valid); end
    checks++; if (frame !== '0) begin errors++; $display("FAIL reset_frame got=%h want=0", frame); end
    checks++; if (frame_seq !== 8'd0) begin errors++; $display("FAIL reset_frame_seq got=%0d want=0", frame_seq); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
  endtask

  task automatic test_directed;
    int vals[8] = '{10, 4, -3, 5, -10, 9, -13, -11};
    do_reset(1);
    for (int k = 0; k < 8; k++) smp[k] = 12'(vals[k]);
    for (int k = 0; k < 8; k++) step(1'b1, k == 0, smp[k], 1'b1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL dir_valid_early got=%b want=0", frame_valid); end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL dir_valid_rise got=%b want=1", frame_valid); end
    checks++; if (frame !== pack_smp(0)) begin errors++; $display("FAIL dir_frame got=%h want=%h", frame, pack_smp(0)); end
    checks++; if (frame_seq !== 8'd0) begin errors++; $display("FAIL dir_seq got=%0d want=0", frame_seq); end
    checks++; if (rdy_lows !== 0) begin errors++; $display("FAIL dir_ready_drops got=%0d want=0", rdy_lows); end
  endtask

  task automatic test_ramp;
    int bad;
    logic [N*W-1:0] ev;
    do_reset(1);
    for (int i = 0; i < 64; i++) step(1'b1, (i % 8) == 0, 12'(i - 32), 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (got_f.size() !== 8) begin errors++; $display("FAIL ramp_count got=%0d want=8", got_f.size()); end
    bad = 0;
    for (int j = 0; j < got_f.size() && j < 8; j++) begin
      for (int k = 0; k < N; k++) ev[k*W +: W] = 12'(j*8 + k - 32);
      if (got_f[j] !== ev || got_s[j] !== 8'(j)) bad++;
      if (j > 0 && xfer_cyc[j] - xfer_cyc[j-1] != 8) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ramp_frames bad=%0d want=0", bad); end
    checks++; if (rdy_lows !== 0) begin errors++; $display("FAIL ramp_ready_drops got=%0d want=0", rdy_lows); end
    checks++; if (state_bad !== 0) begin errors++; $display("FAIL ramp_model state_bad=%0d want=0", state_bad); end
  endtask

  task automatic test_stall;
    do_reset(1);
    for (int i = 0; i < 24; i++) smp[i] = 12'($urandom);
    for (int i = 0; i < 16; i++) step(1'b1, (i % 8) == 0, smp[i], 1'b0);
    checks++; if (rdy_lows !== 0) begin errors++; $display("FAIL stall_fill_ready got=%0d lows want=0", rdy_lows); end
    step(1'b1, 1'b1, smp[16], 1'b0);
    step(1'b1, 1'b1, smp[16], 1'b0);
    checks++; if (last_rdy !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b want=0", last_rdy); end
    checks++; if (frame !== pack_smp(0) || frame_seq !== 8'd0) begin
      errors++; $display("FAIL stall_hold got=%h/%0d want=%h/0", frame, frame_seq, pack_smp(0)); end
    step(1'b1, 1'b1, smp[16], 1'b1);
    checks++; if (last_rdy !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b want=1", last_rdy); end
    checks++; if (frame_seq !== 8'd1 || frame !== pack_smp(8)) begin
      errors++; $display("FAIL stall_move got=%h/%0d want=%h/1", frame, frame_seq, pack_smp(8)); end
    for (int i = 17; i < 24; i++) step(1'b1, 1'b0, smp[i], 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (got_f.size() !== 3) begin errors++; $display("FAIL stall_count got=%0d want=3", got_f.size()); end
    else begin
      checks++; if (got_f[2] !== pack_smp(16) || got_s[2] !== 8'd2) begin
        errors++; $display("FAIL stall_third got=%h/%0d want=%h/2", got_f[2], got_s[2], pack_smp(16)); end
    end
    checks++; if (state_bad !== 0) begin errors++; $display("FAIL stall_model state_bad=%0d want=0", state_bad); end
  endtask

  task automatic test_drop;
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 12'($urandom), 1'b1);
    smp[0] = 12'd100;
    for (int i = 1; i < 8; i++) smp[i] = 12'($urandom);
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, smp[i], 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got=%0d want=1", drop_cnt); end
    checks++; if (got_f.size() !== 1) begin errors++; $display("FAIL drop_count got=%0d want=1", got_f.size()); end
    else begin
      checks++; if (got_f[0] !== pack_smp(0) || got_s[0] !== 8'd0) begin
        errors++; $display("FAIL drop_frame got=%h/%0d want=%h/0", got_f[0], got_s[0], pack_smp(0)); end
    end
  endtask

  task automatic test_midreset;
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 12'($urandom), 1'b1);
    do_reset(1);
    for (int i = 0; i < 8; i++) smp[i] = 12'($urandom);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, smp[i], 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (got_f.size() !== 1) begin errors++; $display("FAIL midrst_count got=%0d want=1", got_f.size()); end
    else begin
      checks++; if (got_f[0] !== pack_smp(0) || got_s[0] !== 8'd0) begin
        errors++; $display("FAIL midrst_frame got=%h/%0d want=%h/0", got_f[0], got_s[0], pack_smp(0)); end
    end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_drop got=%0d want=0", drop_cnt); end
  endtask

  task automatic test_wrap;
    int bad;
    do_reset(1);
    for (int i = 0; i < 300*8; i++) step(1'b1, (i % 8) == 0, 12'($urandom), 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (got_f.size() !== 300) begin errors++; $display("FAIL wrap_count got=%0d want=300", got_f.size()); end
    else begin
      checks++; if (got_s[255] !== 8'd255 || got_s[256] !== 8'd0) begin
        errors++; $display("FAIL wrap_seq got=%0d,%0d want=255,0", got_s[255], got_s[256]); end
    end
    bad = 0;
    for (int j = 0; j < got_f.size(); j++) if (got_f[j] !== exp_f[j] || got_s[j] !== exp_s[j]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_frames bad=%0d want=0", bad); end
    step(1'b1, 1'b1, 12'($urandom), 1'b1);
    for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 12'($urandom), 1'b1);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got=%0d want=255", drop_cnt); end
    checks++; if (state_bad !== 0) begin errors++; $display("FAIL wrap_model state_bad=%0d want=0", state_bad); end
  endtask

  task automatic test_random;
    int bad;
    do_reset(1);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 12'($urandom), $urandom_range(0, 1) == 1);
    repeat (20) step(1'b0, 1'b0, '0, 1'b1);
    bad = 0;
    for (int j = 0; j < got_f.size(); j++) if (got_f[j] !== exp_f[j] || got_s[j] !== exp_s[j]) bad++;
    checks++; if (got_f.size() < 10) begin errors++; $display("FAIL rand_count got=%0d want>=10", got_f.size()); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_frames bad=%0d want=0", bad); end
    checks++; if (state_bad !== 0) begin errors++; $display("FAIL rand_model state_bad=%0d want=0", state_bad); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ramp();
    test_stall();
    test_drop();
    test_midreset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
